wave_capture_store: RTL and testbench



---
 rtl/osc_pkg.sv | 17 +
 rtl/wave_capture_store_if.sv | 53 +++++
 rtl/wave_ram_dp.sv | 30 +++
 rtl/wave_capture_store.sv | 232 +++++++++++++++++++++++
 tb/tb_wave_capture_store.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope capture path: frame geometry and
// the capture state encoding used by the trigger/record controller.
package osc_pkg;

  localparam int OSC_DW  = 12;
  localparam int OSC_AW  = 10;
  localparam int OSC_PRE = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARM,
    S_POST,
    S_DONE
  } cap_state_t;

endpackage

// File: rtl/wave_capture_store_if.sv
// Bundle between the ADC/display side and the capture buffer; the master side
// drives samples, controls and read requests, the slave side returns frame data.
interface wave_capture_store_if
  import osc_pkg::*;
#(
  parameter int DW = OSC_DW,
  parameter int AW = OSC_AW
);

  logic [DW-1:0] ad_data;
  logic          ad_valid;
  logic [11:0]   deci_rate;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          wave_run;
  logic [AW-1:0] wave_addr;
  logic          wave_data_req;
  logic          wr_over;
  logic [DW-1:0] wave_data;
  logic          outrange;
  logic          frame_ready;

  modport master (
    output ad_data,
    output ad_valid,
    output deci_rate,
    output trig_level,
    output trig_edge,
    output wave_run,
    output wave_addr,
    output wave_data_req,
    output wr_over,
    input  wave_data,
    input  outrange,
    input  frame_ready
  );

  modport slave (
    input  ad_data,
    input  ad_valid,
    input  deci_rate,
    input  trig_level,
    input  trig_edge,
    input  wave_run,
    input  wave_addr,
    input  wave_data_req,
    input  wr_over,
    output wave_data,
    output outrange,
    output frame_ready
  );

endinterface

// File: rtl/wave_ram_dp.sv
// Simple dual-port frame RAM: one synchronous write port, one synchronous
// read port, no reset on the storage so it maps onto block RAM.
module wave_ram_dp #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wave_capture_store.sv
// Capture buffer for the scope overlay: decimate the ADC stream, find the trigger,
// store a trigger-centred frame and hold it for display reads until drawing ends.
module wave_capture_store
  import osc_pkg::*;
#(
  parameter int DW  = OSC_DW,
  parameter int AW  = OSC_AW,
  parameter int PRE = OSC_PRE
) (
  input logic                 pix_clk,
  input logic                 rst,
  wave_capture_store_if.slave bus
);

  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'((2 ** AW) - PRE - 2);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);

  cap_state_t    state;
  cap_state_t    next_state;

  logic [11:0]   deci_cnt;
  logic [11:0]   deci_rate_q;
  logic          accept;

  logic [AW-1:0] wptr;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] phase_cnt;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] prev;
  logic          prev_valid;
  logic          crossing;
  logic          sample_clipped;

  logic          clip_flag;
  logic          clip_now;
  logic          outrange_q;

  logic          wr_en;
  logic          enter_pre;
  logic          trig_hit;
  logic          cnt_clr;
  logic          cnt_inc;

  logic [DW-1:0] ram_q;
  logic          req_q;
  logic          done_q;
  logic [DW-1:0] wave_data_q;

  // The rate is reloaded only on a wrap, so a mid-count change never strands the counter.
  assign accept = bus.ad_valid && (deci_cnt == deci_rate_q - 12'd1);

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      deci_cnt    <= '0;
      deci_rate_q <= 12'd1;
    end else if (accept) begin
      deci_cnt    <= '0;
      deci_rate_q <= (bus.deci_rate == 12'd0) ? 12'd1 : bus.deci_rate;
    end else if (bus.ad_valid) begin
      deci_cnt    <= deci_cnt + 12'd1;
    end
  end

  assign sample_clipped = (bus.ad_data == '0) || (bus.ad_data == '1);

  always_comb begin
    crossing = 1'b0;
    if (prev_valid) begin
      if (bus.trig_edge) begin
        crossing = (prev >= bus.trig_level) && (bus.ad_data < bus.trig_level);
      end else begin
        crossing = (prev < bus.trig_level) && (bus.ad_data >= bus.trig_level);
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    enter_pre  = 1'b0;
    trig_hit   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.wave_run) begin
          next_state = S_PRE;
          enter_pre  = 1'b1;
        end
      end
      S_PRE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (phase_cnt == PRE_LAST) begin
            next_state = S_ARM;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (accept) begin
          wr_en = 1'b1;
          if (crossing) begin
            trig_hit   = 1'b1;
            next_state = S_POST;
            cnt_clr    = 1'b1;
          end
        end
      end
      S_POST: begin
        if (accept) begin
          wr_en = 1'b1;
          if (phase_cnt == POST_LAST) begin
            next_state = S_DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.wr_over && bus.wave_run) begin
          next_state = S_PRE;
          enter_pre  = 1'b1;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      phase_cnt <= '0;
    end else if (enter_pre || cnt_clr) begin
      phase_cnt <= '0;
    end else if (cnt_inc) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // The write pointer is never rewound, so frames land anywhere in the ring.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      trig_ptr <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (trig_hit) begin
        trig_ptr <= wptr;
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (enter_pre) begin
      prev_valid <= 1'b0;
    end else if (wr_en) begin
      prev       <= bus.ad_data;
      prev_valid <= 1'b1;
    end
  end

  assign clip_now = clip_flag || (wr_en && sample_clipped);

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      clip_flag  <= 1'b0;
      outrange_q <= 1'b0;
    end else if (enter_pre) begin
      clip_flag  <= 1'b0;
      outrange_q <= 1'b0;
    end else begin
      clip_flag <= clip_now;
      if ((next_state == S_DONE) && (state != S_DONE)) begin
        outrange_q <= clip_now;
      end
    end
  end

  assign rd_addr = trig_ptr - PRE_OFS + bus.wave_addr;

  wave_ram_dp #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (pix_clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (bus.ad_data),
    .re    (bus.wave_data_req),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Read data is forced to zero when the request was made outside DONE.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      wave_data_q <= '0;
    end else begin
      req_q  <= bus.wave_data_req;
      done_q <= (state == S_DONE);
      if (req_q) begin
        wave_data_q <= done_q ? ram_q : '0;
      end
    end
  end

  assign bus.wave_data   = wave_data_q;
  assign bus.outrange    = outrange_q;
  assign bus.frame_ready = (state == S_DONE);

endmodule

// File: tb/tb_wave_capture_store.sv
// Directed bench for wave_capture_store: rising/falling triggers, decimation,
// run/hold, clipping, reads outside DONE and a reset in the middle of POST.
module tb_wave_capture_store;
  import osc_pkg::*;

  logic pix_clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  wave_capture_store_if #(.DW(OSC_DW), .AW(OSC_AW)) bus ();

  wave_capture_store #(
    .DW  (OSC_DW),
    .AW  (OSC_AW),
    .PRE (OSC_PRE)
  ) dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge pix_clk);
  endtask

  task automatic send(input logic [11:0] v);
    bus.ad_data  = v;
    bus.ad_valid = 1'b1;
    @(negedge pix_clk);
    bus.ad_valid = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [9:0] a, input logic [31:0] expected);
    bus.wave_addr     = a;
    bus.wave_data_req = 1'b1;
    @(negedge pix_clk);
    bus.wave_data_req = 1'b0;
    @(negedge pix_clk);
    check_output(tag, 32'(bus.wave_data), expected);
  endtask

  task automatic pulse_wr_over();
    bus.wr_over = 1'b1;
    tick();
    bus.wr_over = 1'b0;
  endtask

  function automatic logic [11:0] hold_sample(input int k);
    if (k <= 512) return 12'd3000;
    if (k == 513) return 12'd4095;
    if (k == 514) return 12'd3000;
    if (k == 515) return 12'd1000;
    if (k == 516) return 12'd3000;
    return 12'd2500;
  endfunction

  function automatic logic [11:0] wrap_sample(input int k);
    if (k < 1020) return 12'(100 + (k % 256));
    return 12'(3000 + (k - 1020));
  endfunction

  initial begin
    rst               = 1'b1;
    bus.ad_data       = '0;
    bus.ad_valid      = 1'b0;
    bus.deci_rate     = 12'd1;
    bus.trig_level    = 12'd2048;
    bus.trig_edge     = 1'b0;
    bus.wave_run      = 1'b0;
    bus.wave_addr     = '0;
    bus.wave_data_req = 1'b0;
    bus.wr_over       = 1'b0;
    tick();
    tick();
    check_output("rst_wave_data", 32'(bus.wave_data), 32'd0);
    check_output("rst_outrange", 32'(bus.outrange), 32'd0);
    check_output("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] rising trigger on a ramp");
    bus.wave_run = 1'b1;
    tick();
    for (int k = 0; k < 1023; k++) send(12'((2048 + 8 * k) % 4096));
    check_output("rise_not_ready", 32'(bus.frame_ready), 32'd0);
    send(12'((2048 + 8 * 1023) % 4096));
    check_output("rise_ready", 32'(bus.frame_ready), 32'd1);
    check_output("rise_outrange", 32'(bus.outrange), 32'd1);
    read_word("rise_addr512", 10'd512, 32'd2048);
    read_word("rise_addr511", 10'd511, 32'd2040);
    read_word("rise_addr0", 10'd0, 32'd2048);
    read_word("rise_addr256", 10'd256, 32'd0);
    read_word("rise_addr1023", 10'd1023, 32'd2040);

    $display("[TB] decimation by 4");
    bus.deci_rate = 12'd4;
    pulse_wr_over();
    check_output("deci_restart_low", 32'(bus.frame_ready), 32'd0);
    for (int j = 0; j < 4092; j++) send(12'(j));
    check_output("deci_not_ready", 32'(bus.frame_ready), 32'd0);
    send(12'd4092);
    check_output("deci_ready", 32'(bus.frame_ready), 32'd1);
    read_word("deci_addr512", 10'd512, 32'd2048);
    read_word("deci_addr511", 10'd511, 32'd2044);
    read_word("deci_addr513", 10'd513, 32'd2052);
    read_word("deci_addr1023", 10'd1023, 32'd4092);

    $display("[TB] falling trigger on a square wave");
    rst = 1'b1;
    #1;
    check_output("rst2_wave_data", 32'(bus.wave_data), 32'd0);
    bus.deci_rate  = 12'd1;
    bus.trig_edge  = 1'b1;
    bus.trig_level = 12'd2000;
    bus.wave_run   = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus.wave_run = 1'b1;
    tick();
    for (int k = 0; k < 1027; k++) send(((k % 8) < 4) ? 12'd3000 : 12'd1000);
    check_output("fall_not_ready", 32'(bus.frame_ready), 32'd0);
    send(12'd3000);
    check_output("fall_ready", 32'(bus.frame_ready), 32'd1);
    check_output("fall_outrange", 32'(bus.outrange), 32'd0);
    read_word("fall_addr511", 10'd511, 32'd3000);
    read_word("fall_addr512", 10'd512, 32'd1000);
    read_word("fall_addr0", 10'd0, 32'd1000);
    read_word("fall_addr516", 10'd516, 32'd3000);
    read_word("fall_addr1023", 10'd1023, 32'd3000);

    $display("[TB] clip, read outside DONE, run/hold");
    bus.trig_edge  = 1'b0;
    bus.trig_level = 12'd2048;
    pulse_wr_over();
    check_output("hold_restart_low", 32'(bus.frame_ready), 32'd0);
    for (int k = 0; k < 1028; k++) begin
      if (k == 514) begin
        bus.wave_addr     = 10'd0;
        bus.wave_data_req = 1'b1;
      end
      if (k == 515) bus.wave_data_req = 1'b0;
      if (k == 700) bus.wave_run = 1'b0;
      if (k == 1027) check_output("hold_not_ready", 32'(bus.frame_ready), 32'd0);
      send(hold_sample(k));
      if (k == 515) check_output("arm_read_zero", 32'(bus.wave_data), 32'd0);
    end
    check_output("hold_ready", 32'(bus.frame_ready), 32'd1);
    check_output("hold_outrange", 32'(bus.outrange), 32'd1);
    read_word("hold_addr512", 10'd512, 32'd3000);
    read_word("hold_addr511", 10'd511, 32'd1000);
    read_word("hold_addr509", 10'd509, 32'd4095);
    read_word("hold_addr600", 10'd600, 32'd2500);
    pulse_wr_over();
    tick();
    check_output("frozen_ready", 32'(bus.frame_ready), 32'd1);
    for (int k = 0; k < 5; k++) send(12'd77);
    read_word("frozen_addr600", 10'd600, 32'd2500);
    read_word("frozen_addr509", 10'd509, 32'd4095);
    check_output("frozen_outrange", 32'(bus.outrange), 32'd1);
    bus.wave_run = 1'b1;
    tick();
    tick();
    check_output("run_no_wr_over", 32'(bus.frame_ready), 32'd1);
    pulse_wr_over();
    check_output("rerun_ready_low", 32'(bus.frame_ready), 32'd0);
    check_output("rerun_outrange_clr", 32'(bus.outrange), 32'd0);

    $display("[TB] reset mid-POST, then a wrapping frame");
    for (int k = 0; k < 613; k++) begin
      send((k < 512) ? 12'd100 : ((k == 512) ? 12'd3000 : 12'd2500));
    end
    rst = 1'b1;
    #1;
    check_output("midpost_wave_data", 32'(bus.wave_data), 32'd0);
    check_output("midpost_outrange", 32'(bus.outrange), 32'd0);
    check_output("midpost_ready", 32'(bus.frame_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_output("restart_ready_low", 32'(bus.frame_ready), 32'd0);
    for (int k = 0; k < 1531; k++) send(wrap_sample(k));
    check_output("wrap_not_ready", 32'(bus.frame_ready), 32'd0);
    send(wrap_sample(1531));
    check_output("wrap_ready", 32'(bus.frame_ready), 32'd1);
    check_output("wrap_outrange", 32'(bus.outrange), 32'd0);
    read_word("wrap_addr512", 10'd512, 32'd3000);
    read_word("wrap_addr511", 10'd511, 32'd351);
    read_word("wrap_addr0", 10'd0, 32'd352);
    read_word("wrap_addr515", 10'd515, 32'd3003);
    read_word("wrap_addr516", 10'd516, 32'd3004);
    read_word("wrap_addr1023", 10'd1023, 32'd3511);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
